// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Purpose  : Single-entry decode pipeline register feeding the register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_instr,
  input  logic [DATA_W-1:0]  in_pc8,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] ra1,
  output logic [RADDR_W-1:0] ra2,
  output logic [RADDR_W-1:0] wa3,
  output logic [DATA_W-1:0]  imm_ext,
  output logic [DATA_W-1:0]  pc8,
  output logic [3:0]         cond,
  output logic [3:0]         alu_cmd,
  output logic               set_flags,
  output logic               reg_write,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               alu_src_imm,
  output logic               branch,
  output logic               illegal
);

  typedef struct packed {
    logic [RADDR_W-1:0] ra1;
    logic [RADDR_W-1:0] ra2;
    logic [RADDR_W-1:0] wa3;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc8;
    logic [3:0]         cond;
    logic [3:0]         alu;
    logic               sf;
    logic               rw;
    logic               mw;
    logic               mtr;
    logic               asi;
    logic               br;
    logic               ill;
  } payload_t;

  payload_t pay_d, pay_q;
  logic     valid_q;

  logic [1:0]          op;
  logic [RADDR_W-1:0]  rn, rd, rm, ra2src;
  logic [DATA_W-1:0]   imm8z;
  logic [2*DATA_W-1:0] rot_w;
  logic                uses_ra1, uses_ra2, hazard, accept;

  assign op     = in_instr[27:26];
  assign rn     = RADDR_W'(in_instr[19:16]);
  assign rd     = RADDR_W'(in_instr[15:12]);
  assign rm     = RADDR_W'(in_instr[3:0]);
  assign imm8z  = {{(DATA_W-8){1'b0}}, in_instr[7:0]};
  assign rot_w  = {imm8z, imm8z} >> {in_instr[11:8], 1'b0};
  assign ra2src = (op == 2'b01) ? rd : rm;

  assign uses_ra1 = ((op == 2'b00) && (in_instr[24:21] != 4'b1101) && (in_instr[24:21] != 4'b1111))
                  || (op == 2'b01);
  assign uses_ra2 = ((op == 2'b00) && !in_instr[25]) || ((op == 2'b01) && !in_instr[20]);

  // Load-use interlock against the load currently held in this stage.
  assign hazard = valid_q && pay_q.mtr &&
                  ((uses_ra1 && (rn == pay_q.wa3)) || (uses_ra2 && (ra2src == pay_q.wa3)));

  assign in_ready = !flush && (!valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    pay_d      = '0;
    pay_d.pc8  = in_pc8;
    pay_d.cond = in_instr[31:28];
    case (op)
      2'b00: begin
        pay_d.ra1 = rn;
        pay_d.ra2 = rm;
        pay_d.wa3 = rd;
        pay_d.alu = in_instr[24:21];
        pay_d.sf  = in_instr[20];
        pay_d.rw  = 1'b1;
        pay_d.asi = in_instr[25];
        if (in_instr[24:23] == 2'b10) begin
          pay_d.rw = 1'b0;
          pay_d.sf = 1'b1;
        end
        if (in_instr[25]) begin
          pay_d.imm = rot_w[DATA_W-1:0];
        end else if (in_instr[11:4] != 8'h00) begin
          pay_d.ill = 1'b1;
        end
      end
      2'b01: begin
        pay_d.ill = in_instr[25] || !in_instr[24] || in_instr[21] || in_instr[22];
        pay_d.ra1 = rn;
        pay_d.ra2 = rd;
        pay_d.wa3 = rd;
        pay_d.imm = {{(DATA_W-12){1'b0}}, in_instr[11:0]};
        pay_d.asi = 1'b1;
        pay_d.alu = in_instr[23] ? 4'b0100 : 4'b0010;
        if (in_instr[20]) begin
          pay_d.rw  = 1'b1;
          pay_d.mtr = 1'b1;
        end else begin
          pay_d.mw  = 1'b1;
        end
      end
      2'b10: begin
        if (in_instr[25] && !in_instr[24]) begin
          pay_d.ra1 = '1;
          pay_d.imm = {{(DATA_W-26){in_instr[23]}}, in_instr[23:0], 2'b00};
          pay_d.alu = 4'b0100;
          pay_d.asi = 1'b1;
          pay_d.br  = 1'b1;
        end else begin
          pay_d.ill = 1'b1;
        end
      end
      default: pay_d.ill = 1'b1;
    endcase
    // The NV condition space (cond=1111) holds no supported encodings.
    if (in_instr[31:28] == 4'hF) pay_d.ill = 1'b1;
    if (pay_d.ill) begin
      pay_d.rw  = 1'b0;
      pay_d.mw  = 1'b0;
      pay_d.mtr = 1'b0;
      pay_d.br  = 1'b0;
      pay_d.sf  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pay_q   <= pay_d;
    end else if (out_ready || !valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign ra1         = pay_q.ra1;
  assign ra2         = pay_q.ra2;
  assign wa3         = pay_q.wa3;
  assign imm_ext     = pay_q.imm;
  assign pc8         = pay_q.pc8;
  assign cond        = pay_q.cond;
  assign alu_cmd     = pay_q.alu;
  assign set_flags   = pay_q.sf;
  assign reg_write   = pay_q.rw;
  assign mem_write   = pay_q.mw;
  assign mem_to_reg  = pay_q.mtr;
  assign alu_src_imm = pay_q.asi;
  assign branch      = pay_q.br;
  assign illegal     = pay_q.ill;

endmodule

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly upstream of the register file: registers one fetched instruction, decodes it, and presents read/write register addresses plus control for the register file and execute.
- Holds a single instruction (one pipeline register) with valid/ready handshake on both sides.
- Supports flush on a taken branch and inserts a one-cycle load-use interlock.

Parameters:
DATA_W, 32, instruction/immediate/PC width
RADDR_W, 4, register address width (R0-R15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
flush  in  1  kill held instruction, block acceptance this cycle
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  DATA_W  instruction word
in_pc8  in  DATA_W  fetch address + 8
out_valid  out  1  decoded instruction valid
out_ready  in  1  downstream consumes this cycle
ra1, ra2, wa3  out  RADDR_W  register file read addresses 1/2, write address
imm_ext  out  DATA_W  extended immediate
pc8  out  DATA_W  registered in_pc8
cond  out  4  instr[31:28]
alu_cmd  out  4  ALU command
set_flags, reg_write, mem_write, mem_to_reg, alu_src_imm, branch, illegal  out  1 each  control

Behaviour:
- Reset (rst=0, async): out_valid=0; every payload output=0. After release, in_ready=1 (empty stage).
- in_ready = !flush && (!out_valid || out_ready) && !hazard. Accept = in_valid && in_ready. Accepted instruction appears on outputs next edge (latency 1); out_valid=1.
- Stall: out_valid && !out_ready -> all outputs held bit-stable.
- No accept and (out_ready || !out_valid) -> out_valid=0 next edge.
- flush: next edge out_valid=0, nothing accepted. If out_valid && out_ready in the same cycle, that transfer still counts as complete.
- Decode, op=instr[27:26]; Rn=[19:16], Rd=[15:12], Rm=[3:0]:
  - 00 data-processing:
    - I=[25]; alu_cmd=[24:21]; set_flags=[20]; ra1=Rn; ra2=Rm; wa3=Rd; reg_write=1; alu_src_imm=I.
    - cmd 1000-1011 (TST/TEQ/CMP/CMN): reg_write=0, set_flags forced 1.
    - I=1: imm_ext = zero-extend [7:0] rotated right by 2*[11:8].
    - I=0: imm_ext=0; [11:4]!=0 -> illegal.
  - 01 memory:
    - Requires I=[25]=0, P=[24]=1, W=[21]=0, B=[22]=0; else illegal.
    - ra1=Rn; ra2=Rd; wa3=Rd; imm_ext = zero-extend [11:0]; alu_src_imm=1; alu_cmd = U=[23] ? 0100 : 0010.
    - L=[20]=1: reg_write=1, mem_to_reg=1. L=0: mem_write=1.
  - 10 with [25]=1, [24]=0, branch:
    - ra1=15; imm_ext = sign-extend [23:0] << 2; alu_cmd=0100; alu_src_imm=1; branch=1.
    - [25]=0 or [24]=1 -> illegal.
  - 11: illegal.
- illegal=1: out_valid still 1; reg_write=mem_write=mem_to_reg=branch=set_flags=0; addresses don't care.
- Unused control bits are 0. wa3=15 with reg_write=1 passes through unchanged; PC redirect is handled downstream.
- Read usage:
  - uses_ra1 = DP with cmd not MOV(1101)/MVN(1111), or memory.
  - uses_ra2 = DP with I=0, or STR.
- hazard = out_valid && mem_to_reg && ((uses_ra1 && Rn==wa3) || (uses_ra2 && ra2src==wa3)), evaluated on in_instr.
- Hazard effect: consumer sees exactly one out_valid=0 cycle after the LDR when out_ready=1.
- Reset mid-stall or mid-hazard: instruction discarded, state as reset.

Test Plan:
- Reset, then 0xE2821005 (ADD R1,R2,#5) with out_ready=1 -> next cycle out_valid=1, ra1=2, wa3=1, imm_ext=5, alu_cmd=0100, reg_write=1, alu_src_imm=1.
- 0xE3A004FF (MOV R0,#0xFF ror 8) -> imm_ext=0xFF000000. Then 0xE3510000 (CMP R1,#0) -> reg_write=0, set_flags=1, alu_cmd=1010.
- 0xE5903004 (LDR R3,[R0,#4]) then 0xE0834003 (ADD R4,R3,R3), out_ready=1 -> LDR out with mem_to_reg=1, wa3=3, imm_ext=4. in_ready=0 one cycle; out_valid=0 one cycle; then ADD out with ra1=3, ra2=3.
- 0xEAFFFFFE (B .-0) -> ra1=15, imm_ext=0xFFFFFFF8, branch=1. 0xF0000000, 0xE8000000 -> illegal=1, out_valid=1, reg_write=0.
- Hold out_ready=0 three cycles with in_valid=1 -> outputs stable, in_ready=0. Assert flush one cycle -> out_valid=0 next edge, new instruction not taken.
- Drop rst mid-stall, asynchronously between edges -> out_valid=0 and outputs=0 immediately. After release, first instruction decodes normally.
